// File: rtl/combat_pkg.sv
// Shared encodings and width constants for the combat resolver.
// Player states, game states, winner codes and a saturating subtract helper.
package combat_pkg;

    localparam int HEALTH_W   = 8;
    localparam int COOLDOWN_W = 4;

    typedef enum logic [1:0] {
        PS_INIT     = 2'd0,
        PS_PUNCHING = 2'd1,
        PS_BLOCKING = 2'd2,
        PS_INVALID  = 2'd3
    } player_state_e;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_FIGHT = 2'd1,
        GS_OVER  = 2'd2
    } game_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] value,
        input logic [HEALTH_W-1:0] amount
    );
        if (value > amount) begin
            return value - amount;
        end else begin
            return {HEALTH_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/health_tracker.sv
// Per-player health register, invulnerability cooldown and hit pulse.
// Macro COMBAT_CHIP_DAMAGE_EN makes blocked punches deal chip damage as full hits.
module health_tracker
    import combat_pkg::*;
#(
    parameter logic [HEALTH_W-1:0]   MAX_HEALTH   = 8'd100,
    parameter logic [HEALTH_W-1:0]   PUNCH_DAMAGE = 8'd10,
    parameter logic [HEALTH_W-1:0]   CHIP_DAMAGE  = 8'd2,
    parameter logic [COOLDOWN_W-1:0] HIT_COOLDOWN = 4'd8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                load,
    input  logic                attack,
    input  logic                blocked,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] health_next,
    output logic                hit
);

    logic [HEALTH_W-1:0]   health_r;
    logic [HEALTH_W-1:0]   health_next_s;
    logic [HEALTH_W-1:0]   damage_s;
    logic [COOLDOWN_W-1:0] cooldown_r;
    logic                  apply_s;
    logic                  hit_r;

    // Decide whether an incoming attack lands and what health it leaves
    always_comb begin
        damage_s = blocked ? CHIP_DAMAGE : PUNCH_DAMAGE;
`ifdef COMBAT_CHIP_DAMAGE_EN
        apply_s = tick && attack && (cooldown_r == {COOLDOWN_W{1'b0}});
`else
        apply_s = tick && attack && !blocked && (cooldown_r == {COOLDOWN_W{1'b0}});
`endif
        if (apply_s) begin
            health_next_s = sat_sub(health_r, damage_s);
        end else begin
            health_next_s = health_r;
        end
    end

    // Health, cooldown and self-clearing hit pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            health_r   <= MAX_HEALTH;
            cooldown_r <= {COOLDOWN_W{1'b0}};
            hit_r      <= 1'b0;
        end else begin
            hit_r <= apply_s;
            if (tick) begin
                if (load) begin
                    health_r   <= MAX_HEALTH;
                    cooldown_r <= {COOLDOWN_W{1'b0}};
                end else begin
                    health_r <= health_next_s;
                    if (apply_s) begin
                        cooldown_r <= HIT_COOLDOWN;
                    end else if (cooldown_r != {COOLDOWN_W{1'b0}}) begin
                        cooldown_r <= cooldown_r - {{(COOLDOWN_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    assign health      = health_r;
    assign health_next = health_next_s;
    assign hit         = hit_r;

endmodule

// File: rtl/combat_resolver.sv
// Two-player combat resolver: punch edge detection, damage and game flow.
// Optional macro COMBAT_CHIP_DAMAGE_EN enables chip damage through blocks.
module combat_resolver
    import combat_pkg::*;
#(
    parameter logic [HEALTH_W-1:0]   MAX_HEALTH   = 8'd100,
    parameter logic [HEALTH_W-1:0]   PUNCH_DAMAGE = 8'd10,
    parameter logic [HEALTH_W-1:0]   CHIP_DAMAGE  = 8'd2,
    parameter logic [COOLDOWN_W-1:0] HIT_COOLDOWN = 4'd8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                finished,
    input  logic                start,
    input  logic [1:0]          p1_state,
    input  logic [1:0]          p2_state,
    input  logic                p1_resting,
    input  logic                p2_resting,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_hit,
    output logic                p2_hit,
    output logic [1:0]          game_state,
    output logic [1:0]          winner
);

    game_state_e         state_r;
    logic [1:0]          winner_r;
    logic                p1_prev_r, p2_prev_r;
    logic                p1_punch_s, p2_punch_s, p1_block_s, p2_block_s;
    logic                p1_attack_s, p2_attack_s, load_s;
    logic [HEALTH_W-1:0] p1_next_s, p2_next_s;

    // Active punch/block decode and rising-edge attacks, live only in FIGHT
    always_comb begin
        p1_punch_s  = (p1_state == PS_PUNCHING) && !p1_resting;
        p2_punch_s  = (p2_state == PS_PUNCHING) && !p2_resting;
        p1_block_s  = (p1_state == PS_BLOCKING) && !p1_resting;
        p2_block_s  = (p2_state == PS_BLOCKING) && !p2_resting;
        p1_attack_s = (state_r == GS_FIGHT) && p1_punch_s && !p1_prev_r;
        p2_attack_s = (state_r == GS_FIGHT) && p2_punch_s && !p2_prev_r;
        load_s      = (state_r == GS_IDLE) && start;
    end

    // Each tracker is the victim of the opposite player's attack
    health_tracker #(
        .MAX_HEALTH(MAX_HEALTH), .PUNCH_DAMAGE(PUNCH_DAMAGE),
        .CHIP_DAMAGE(CHIP_DAMAGE), .HIT_COOLDOWN(HIT_COOLDOWN)
    ) u_p1 (
        .clk(clk), .rst(rst), .tick(finished), .load(load_s),
        .attack(p2_attack_s), .blocked(p1_block_s),
        .health(p1_health), .health_next(p1_next_s), .hit(p1_hit)
    );

    health_tracker #(
        .MAX_HEALTH(MAX_HEALTH), .PUNCH_DAMAGE(PUNCH_DAMAGE),
        .CHIP_DAMAGE(CHIP_DAMAGE), .HIT_COOLDOWN(HIT_COOLDOWN)
    ) u_p2 (
        .clk(clk), .rst(rst), .tick(finished), .load(load_s),
        .attack(p1_attack_s), .blocked(p2_block_s),
        .health(p2_health), .health_next(p2_next_s), .hit(p2_hit)
    );

    // Game flow FSM with previous-punch history; knockout judged on post-damage health
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= GS_IDLE;
            winner_r  <= WIN_NONE;
            p1_prev_r <= 1'b0;
            p2_prev_r <= 1'b0;
        end else if (finished) begin
            p1_prev_r <= p1_punch_s;
            p2_prev_r <= p2_punch_s;
            case (state_r)
                GS_IDLE: begin
                    if (start) begin
                        state_r   <= GS_FIGHT;
                        winner_r  <= WIN_NONE;
                        p1_prev_r <= 1'b0;
                        p2_prev_r <= 1'b0;
                    end
                end
                GS_FIGHT: begin
                    if ((p1_next_s == {HEALTH_W{1'b0}}) || (p2_next_s == {HEALTH_W{1'b0}})) begin
                        state_r  <= GS_OVER;
                        winner_r <= {(p1_next_s == {HEALTH_W{1'b0}}),
                                     (p2_next_s == {HEALTH_W{1'b0}})};
                    end
                end
                GS_OVER: begin
                    if (start) begin
                        state_r <= GS_IDLE;
                    end
                end
                default: begin
                    state_r  <= GS_IDLE;
                    winner_r <= WIN_NONE;
                end
            endcase
        end
    end

    assign game_state = state_r;
    assign winner     = winner_r;

endmodule

// File: tb/tb_combat_resolver.sv
// Self-checking bench for combat_resolver: directed scenarios plus random play
// against a tick-level game model; honours COMBAT_CHIP_DAMAGE_EN.
module tb_combat_resolver;

`ifdef COMBAT_CHIP_DAMAGE_EN
    localparam bit CHIP_EN = 1'b1;
`else
    localparam bit CHIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       finished = 1'b0;
    logic       start = 1'b0;
    logic [1:0] p1_state = 2'd0, p2_state = 2'd0;
    logic       p1_resting = 1'b0, p2_resting = 1'b0;
    logic [7:0] p1_health, p2_health;
    logic       p1_hit, p2_hit;
    logic [1:0] game_state, winner;

    int errors = 0;
    int checks = 0;

    // Game model: 0=IDLE 1=FIGHT 2=OVER
    int m_gs, m_win;
    int m_h[2], m_cd[2], m_prev[2], m_hit[2];

    combat_resolver dut (
        .clk(clk), .rst(rst), .finished(finished), .start(start),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_resting(p1_resting), .p2_resting(p2_resting),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .game_state(game_state), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gs = 0; m_win = 0;
        for (int i = 0; i < 2; i++) begin
            m_h[i] = 100; m_cd[i] = 0; m_prev[i] = 0; m_hit[i] = 0;
        end
    endtask

    task automatic model_clock();
        int ap[2], ab[2], dmg, landed;
        m_hit[0] = 0;
        m_hit[1] = 0;
        if (!finished) return;
        ap[0] = (p1_state == 2'd1 && !p1_resting) ? 1 : 0;
        ap[1] = (p2_state == 2'd1 && !p2_resting) ? 1 : 0;
        ab[0] = (p1_state == 2'd2 && !p1_resting) ? 1 : 0;
        ab[1] = (p2_state == 2'd2 && !p2_resting) ? 1 : 0;
        for (int v = 0; v < 2; v++) begin
            landed = 0;
            dmg = 0;
            if (m_gs == 1 && ap[1-v] == 1 && m_prev[1-v] == 0 && m_cd[v] == 0) begin
                if (ab[v] == 1) begin
                    if (CHIP_EN) begin landed = 1; dmg = 2; end
                end else begin
                    landed = 1; dmg = 10;
                end
            end
            if (landed == 1) begin
                m_h[v] = (m_h[v] > dmg) ? m_h[v] - dmg : 0;
                m_cd[v] = 8;
                m_hit[v] = 1;
            end else if (m_cd[v] > 0) begin
                m_cd[v]--;
            end
        end
        m_prev[0] = ap[0];
        m_prev[1] = ap[1];
        case (m_gs)
            0: if (start) begin
                m_gs = 1; m_win = 0;
                for (int i = 0; i < 2; i++) begin m_h[i] = 100; m_cd[i] = 0; m_prev[i] = 0; end
            end
            1: if (m_h[0] == 0 || m_h[1] == 0) begin
                m_gs = 2;
                m_win = (m_h[1] == 0 ? 1 : 0) + (m_h[0] == 0 ? 2 : 0);
            end
            default: if (start) m_gs = 0;
        endcase
    endtask

    task automatic compare_all();
        check("p1_health", int'(p1_health), m_h[0]);
        check("p2_health", int'(p2_health), m_h[1]);
        check("p1_hit", int'(p1_hit), m_hit[0]);
        check("p2_hit", int'(p2_hit), m_hit[1]);
        check("game_state", int'(game_state), m_gs);
        check("winner", int'(winner), m_win);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        finished = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic [1:0] s1, input logic r1,
                         input logic [1:0] s2, input logic r2);
        p1_state = s1; p1_resting = r1; p2_state = s2; p2_resting = r2;
    endtask

    task automatic new_fight();
        drive(2'd0, 1'b0, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rst = 1'b1;
        start = 1'b1;
        ticks(1);
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [7:0] snap_h1, snap_h2;
        logic [1:0] snap_gs, snap_win;

        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Start then single P1 punch held for 20 more ticks
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        check("started", int'(game_state), 1);
        drive(2'd1, 1'b0, 2'd0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 21; i++) begin
            ticks(1);
            pulses += int'(p2_hit);
        end
        check("single_punch_health", int'(p2_health), 90);
        check("single_punch_pulses", pulses, 1);

        // Blocked punch from fresh health
        new_fight();
        drive(2'd0, 1'b0, 2'd2, 1'b0);
        ticks(1);
        drive(2'd1, 1'b0, 2'd2, 1'b0);
        ticks(2);
        check("blocked_health", int'(p2_health), CHIP_EN ? 98 : 100);

        // Cooldown: edges at t=0, t=3 (ignored) and t=9
        new_fight();
        for (int t = 0; t < 10; t++) begin
            drive((t == 0 || t == 3 || t == 9) ? 2'd1 : 2'd0, 1'b0, 2'd0, 1'b0);
            ticks(1);
            if (t == 3) check("cooldown_ignored", int'(p2_health), 90);
        end
        check("cooldown_expired", int'(p2_health), 80);

        // Simultaneous punches down to 10/10 then a double knockout
        new_fight();
        for (int r = 0; r < 9; r++) begin
            drive(2'd1, 1'b0, 2'd1, 1'b0);
            ticks(1);
            drive(2'd0, 1'b0, 2'd0, 1'b0);
            ticks(9);
        end
        check("pre_ko_p1", int'(p1_health), 10);
        check("pre_ko_p2", int'(p2_health), 10);
        drive(2'd1, 1'b0, 2'd1, 1'b0);
        ticks(1);
        check("ko_state", int'(game_state), 2);
        check("ko_winner", int'(winner), 3);
        check("ko_p1", int'(p1_health), 0);
        drive(2'd0, 1'b0, 2'd0, 1'b0);
        start = 1'b1;
        ticks(1);
        start = 1'b0;
        check("over_to_idle", int'(game_state), 0);
        check("idle_holds_winner", int'(winner), 3);

        // Mid-fight reset while a hit pulse is high and p1_health=40
        new_fight();
        for (int k = 0; k < 6; k++) begin
            drive(2'd0, 1'b0, 2'd1, 1'b0);
            ticks(1);
            if (k < 5) begin
                drive(2'd0, 1'b0, 2'd0, 1'b0);
                ticks(9);
            end
        end
        check("pre_reset_health", int'(p1_health), 40);
        check("pre_reset_pulse", int'(p1_hit), 1);
        finished = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_state", int'(game_state), 0);
        check("rst_p1_health", int'(p1_health), 100);
        check("rst_p2_health", int'(p2_health), 100);
        check("rst_winner", int'(winner), 0);
        check("rst_pulse", int'(p1_hit), 0);
        model_reset();
        drive(2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Frame gate held low while inputs toggle
        new_fight();
        drive(2'd1, 1'b0, 2'd0, 1'b0);
        ticks(1);
        finished = 1'b0;
        step();
        snap_h1 = p1_health; snap_h2 = p2_health; snap_gs = game_state; snap_win = winner;
        for (int i = 0; i < 50; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            start = 1'($urandom_range(0, 1));
            step();
        end
        check("gate_p1_health", int'(p1_health), int'(snap_h1));
        check("gate_p2_health", int'(p2_health), int'(snap_h2));
        check("gate_state", int'(game_state), int'(snap_gs));
        check("gate_winner", int'(winner), int'(snap_win));
        check("gate_pulse", int'(p2_hit), 0);
        start = 1'b0;

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
            start = 1'($urandom_range(0, 9) == 0);
            finished = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
COMBAT_RESOLVER -- requirements
Module: combat_resolver

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 8'd100, the starting health of each player.
REQ-002 SHALL have parameter PUNCH_DAMAGE, default 8'd10, the damage dealt by an unblocked punch.
REQ-003 SHALL have parameter CHIP_DAMAGE, default 8'd2, the damage dealt by a blocked punch.
REQ-004 SHALL have parameter HIT_COOLDOWN, default 4'd8, the number of frames of invulnerability after taking a hit.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port finished  in  1  frame tick; all state advances only on cycles where finished=1.
REQ-008 SHALL have port start  in  1  start or restart request, sampled on frame ticks.
REQ-009 SHALL have ports p1_state and p2_state  in  2  player state: 0=INIT, 1=PUNCHING, 2=BLOCKING, 3=invalid.
REQ-010 SHALL have ports p1_resting and p2_resting  in  1  player resting flag.
REQ-011 SHALL have ports p1_health and p2_health  out  8  current health of each player.
REQ-012 SHALL have ports p1_hit and p2_hit  out  1  registered, one-frame-tick-cycle pulse marking that player as damaged.
REQ-013 SHALL have port game_state  out  2  0=IDLE, 1=FIGHT, 2=OVER.
REQ-014 SHALL have port winner  out  2  00=none, 01=P1, 10=P2, 11=draw.

Function
REQ-015 SHALL define active punch as state==PUNCHING && !resting, and active block as state==BLOCKING && !resting; invalid state (3) counts as neither.
REQ-016 SHALL keep a registered copy of each player's active-punch value, updated on every frame tick.
REQ-017 SHALL detect a punch only on the rising edge of active punch (prev=0, current=1), so each punch lands at most once.
REQ-018 SHALL, in FIGHT, apply a punch by Px to the opponent only when the opponent's cooldown is 0.
- Opponent active block: damage = CHIP_DAMAGE.
- Otherwise: damage = PUNCH_DAMAGE.
REQ-019 SHALL subtract damage with saturation at 0, with no wrap-around.
REQ-020 SHALL, on each applied hit, pulse the victim's hit output for exactly one clk cycle (the cycle after the tick) and load the victim's cooldown with HIT_COOLDOWN.
REQ-021 SHALL decrement each non-zero cooldown by 1 per frame tick; a cooldown reload takes priority over the decrement.
REQ-022 SHALL, when both players punch on the same tick, resolve both hits independently in that tick.
REQ-023 SHALL implement these game_state transitions on frame ticks:
- IDLE to FIGHT on start: health loaded to MAX_HEALTH, cooldowns and previous-punch registers cleared, winner=00.
- FIGHT to OVER when post-damage health of either player is 0: winner=01 if p2 is at 0, 10 if p1 is at 0, 11 if both are at 0.
- OVER to IDLE on start: health and winner are held until the next IDLE to FIGHT transition.
REQ-024 SHALL ignore start while in FIGHT.
REQ-025 SHALL ignore punches in IDLE and OVER, with no damage, pulses or cooldown loads.
REQ-026 SHALL ignore all inputs when finished=0, holding every output and register; hit pulses still self-clear.

Reset
REQ-027 SHALL asynchronously set, while rst=0: game_state=IDLE, winner=00, p1_health=p2_health=MAX_HEALTH, hit pulses=0, cooldowns=0, previous-punch registers=0.
REQ-028 SHALL take effect mid-fight immediately, regardless of finished.

Configuration
REQ-029 SHALL honour macro COMBAT_CHIP_DAMAGE_EN.
- Defined: blocked punches cost CHIP_DAMAGE and act as full hits (pulse and cooldown).
- Undefined: a blocked punch causes no damage, no hit pulse and no cooldown load, and CHIP_DAMAGE is unused.

Structure
REQ-030 SHALL place in shared package combat_pkg: the player-state encoding (INIT/PUNCHING/BLOCKING), the game_state enum, the winner encoding, and the health and cooldown width constants.
REQ-031 SHALL use one sub-module, health_tracker, instantiated per player: health register, saturating subtract, cooldown counter and hit pulse.

Verification (defaults: MAX=100, PUNCH=10, CHIP=2, COOLDOWN=8)
REQ-032 SHALL cover: start, then a P1 punch (state 0 to 1, resting=0) on one tick -> p2_health=90 and p2_hit pulses once; holding the punch for 20 ticks -> no further damage.
REQ-033 SHALL cover: P2 BLOCKING with resting=0 while P1 punches -> p2_health=98 with macro defined, 100 with macro undefined.
REQ-034 SHALL cover: two P1 punch rising edges 3 ticks apart -> second one ignored (cooldown), p2_health=90; a third edge 9 ticks after the first -> p2_health=80.
REQ-035 SHALL cover: both players punch on the same tick with health 10/10 -> both 0, game_state=OVER, winner=11.
REQ-036 SHALL cover: rst asserted mid-fight with p1_health=40 -> immediately IDLE, health 100/100, winner=00, no hit pulse.
REQ-037 SHALL cover: finished held 0 for 50 cycles while inputs toggle -> all outputs unchanged.
